// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 data-memory arbiter.
package y86_mem_pkg;

    localparam int DW                 = 64;
    localparam int CNT_W              = 4;
    localparam int LAT_DEFAULT        = 1;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_M = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        if (v >= lim) begin
            return lim;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports (M and D) plus the data-memory side of the arbiter.
interface dmem_arbiter_if;

    logic                       m_req;
    logic                       m_we;
    logic [y86_mem_pkg::DW-1:0] m_addr;
    logic [y86_mem_pkg::DW-1:0] m_wdata;
    logic                       m_gnt;
    logic                       m_rvalid;
    logic                       m_err;
    logic [y86_mem_pkg::DW-1:0] m_rdata;

    logic                       d_req;
    logic                       d_we;
    logic [y86_mem_pkg::DW-1:0] d_addr;
    logic [y86_mem_pkg::DW-1:0] d_wdata;
    logic                       d_gnt;
    logic                       d_rvalid;
    logic                       d_err;
    logic [y86_mem_pkg::DW-1:0] d_rdata;

    logic                       mem_rEn;
    logic                       mem_wEn;
    logic [y86_mem_pkg::DW-1:0] mem_addr;
    logic [y86_mem_pkg::DW-1:0] mem_wdata;
    logic [y86_mem_pkg::DW-1:0] mem_rdata;
    logic                       mem_err;

    logic                       busy;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_err,
        output m_gnt, m_rvalid, m_err, m_rdata,
        output d_gnt, d_rvalid, d_err, d_rdata,
        output mem_rEn, mem_wEn, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_err,
        input  m_gnt, m_rvalid, m_err, m_rdata,
        input  d_gnt, d_rvalid, d_err, d_rdata,
        input  mem_rEn, mem_wEn, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/dmem_starve_arb.sv
// M-over-D priority select with a starvation counter that hands D the
// grant after STARVE_MAX back-to-back M grants.
module dmem_starve_arb
    import y86_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en_i,
    input  logic m_req_i,
    input  logic d_req_i,
    output logic m_gnt_o,
    output logic d_gnt_o
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    // Grant select: D only wins when M is absent or D has been starved out.
    always_comb begin
        m_gnt_o = 1'b0;
        d_gnt_o = 1'b0;
        if (arb_en_i) begin
            if (d_req_i && (!m_req_i || (starve_q == STARVE_LIM))) begin
                d_gnt_o = 1'b1;
            end else if (m_req_i) begin
                m_gnt_o = 1'b1;
            end else begin
                m_gnt_o = 1'b0;
            end
        end else begin
            d_gnt_o = 1'b0;
        end
    end

    // Starvation count next-state.
    always_comb begin
        starve_d = starve_q;
        if (!d_req_i || d_gnt_o) begin
            starve_d = '0;
        end else if (m_gnt_o) begin
            starve_d = sat_inc(starve_q, STARVE_LIM);
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (M stage / loader-debug) arbiter in front of a fixed-latency data
// memory; one outstanding access at a time, IDLE -> ISSUE -> [WAIT] -> RESP.
module dmem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int LAT        = LAT_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LAT - 2);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;
    owner_e           owner_q;
    logic             we_q;
    logic [DW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;

    logic             arb_en_s;
    logic             m_gnt_s;
    logic             d_gnt_s;
    logic             in_access_s;

    // Gating with rst_n keeps gnt low during reset even though state is IDLE.
    assign arb_en_s    = (state_q == ST_IDLE) && rst_n;
    assign in_access_s = (state_q != ST_IDLE);

    dmem_starve_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .arb_en_i (arb_en_s),
        .m_req_i  (bus.m_req),
        .d_req_i  (bus.d_req),
        .m_gnt_o  (m_gnt_s),
        .d_gnt_o  (d_gnt_s)
    );

    // Access sequencing; WAIT counts LAT-1 cycles between ISSUE and RESP.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (m_gnt_s || d_gnt_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wait_d = '0;
                if (LAT > 1) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and request capture at the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            owner_q <= OWN_M;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (d_gnt_s) begin
                owner_q <= OWN_D;
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end else if (m_gnt_s) begin
                owner_q <= OWN_M;
                we_q    <= bus.m_we;
                addr_q  <= bus.m_addr;
                wdata_q <= bus.m_wdata;
            end else begin
                owner_q <= owner_q;
            end
        end
    end

    // Output decode; everything but gnt is a function of registered state.
    always_comb begin
        bus.m_gnt     = m_gnt_s;
        bus.d_gnt     = d_gnt_s;
        bus.m_rvalid  = 1'b0;
        bus.m_err     = 1'b0;
        bus.m_rdata   = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_err     = 1'b0;
        bus.d_rdata   = '0;
        bus.busy      = in_access_s;
        bus.mem_wEn   = (state_q == ST_ISSUE) && we_q;
        bus.mem_rEn   = in_access_s && !we_q;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (in_access_s) begin
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
        end else begin
            bus.mem_addr  = '0;
        end
        if (state_q == ST_RESP) begin
            if (owner_q == OWN_D) begin
                bus.d_rvalid = 1'b1;
                bus.d_err    = bus.mem_err;
                bus.d_rdata  = we_q ? '0 : bus.mem_rdata;
            end else begin
                bus.m_rvalid = 1'b1;
                bus.m_err    = bus.mem_err;
                bus.m_rdata  = we_q ? '0 : bus.mem_rdata;
            end
        end else begin
            bus.m_rvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: one arbiter at LAT=1 and one at LAT=3, sharing clk/rst_n.
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dmem_arbiter_if b1();
    dmem_arbiter_if b3();

    dmem_arbiter #(.LAT(1), .STARVE_MAX(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    dmem_arbiter #(.LAT(3), .STARVE_MAX(4)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    int gseq [10];
    int exp_seq [10];
    int gcount;
    int both_gnt;
    int both_rv;

    initial begin
        checks = 0;
        errors = 0;
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rst_n = 1'b0;
        b1.m_req = 1'b0; b1.m_we = 1'b0; b1.m_addr = '0; b1.m_wdata = '0;
        b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        b1.mem_rdata = '0; b1.mem_err = 1'b0;
        b3.m_req = 1'b0; b3.m_we = 1'b0; b3.m_addr = '0; b3.m_wdata = '0;
        b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
        b3.mem_rdata = '0; b3.mem_err = 1'b0;

        // Reset: outputs 0 and no grant even with a request present.
        @(negedge clk);
        b1.m_req = 1'b1;
        #1;
        check("rst_m_gnt", 64'(b1.m_gnt), 64'd0);
        check("rst_busy", 64'(b1.busy), 64'd0);
        check("rst_mem_addr", b1.mem_addr, 64'd0);
        b1.m_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // M read at 0x100, LAT=1.
        @(negedge clk);
        b1.m_req = 1'b1; b1.m_we = 1'b0; b1.m_addr = 64'h100;
        #1;
        check("rd_gnt_T", 64'(b1.m_gnt), 64'd1);
        check("rd_rEn_T", 64'(b1.mem_rEn), 64'd0);
        @(negedge clk);
        b1.m_req = 1'b0; b1.mem_rdata = 64'hDEAD;
        #1;
        check("rd_gnt_T1", 64'(b1.m_gnt), 64'd0);
        check("rd_rEn_T1", 64'(b1.mem_rEn), 64'd1);
        check("rd_addr_T1", b1.mem_addr, 64'h100);
        check("rd_rvalid_T1", 64'(b1.m_rvalid), 64'd0);
        @(negedge clk);
        #1;
        check("rd_rvalid_T2", 64'(b1.m_rvalid), 64'd1);
        check("rd_rdata_T2", b1.m_rdata, 64'hDEAD);
        check("rd_rEn_T2", 64'(b1.mem_rEn), 64'd1);
        check("rd_d_rvalid_T2", 64'(b1.d_rvalid), 64'd0);
        @(negedge clk);
        #1;
        check("rd_busy_T3", 64'(b1.busy), 64'd0);
        check("rd_rEn_T3", 64'(b1.mem_rEn), 64'd0);
        check("rd_rvalid_T3", 64'(b1.m_rvalid), 64'd0);

        // M write 0x55 to 0x40.
        @(negedge clk);
        b1.m_req = 1'b1; b1.m_we = 1'b1; b1.m_addr = 64'h40; b1.m_wdata = 64'h55;
        b1.mem_rdata = 64'hBEEF;
        #1;
        check("wr_gnt_T", 64'(b1.m_gnt), 64'd1);
        check("wr_wEn_T", 64'(b1.mem_wEn), 64'd0);
        @(negedge clk);
        b1.m_req = 1'b0; b1.m_we = 1'b0;
        #1;
        check("wr_wEn_T1", 64'(b1.mem_wEn), 64'd1);
        check("wr_addr_T1", b1.mem_addr, 64'h40);
        check("wr_wdata_T1", b1.mem_wdata, 64'h55);
        check("wr_rEn_T1", 64'(b1.mem_rEn), 64'd0);
        @(negedge clk);
        #1;
        check("wr_wEn_T2", 64'(b1.mem_wEn), 64'd0);
        check("wr_rvalid_T2", 64'(b1.m_rvalid), 64'd1);
        check("wr_rdata_T2", b1.m_rdata, 64'd0);
        @(negedge clk);
        #1;
        check("wr_busy_T3", 64'(b1.busy), 64'd0);
        check("wr_wdata_T3", b1.mem_wdata, 64'd0);

        // Both ports requesting continuously: expect M,M,M,M,D repeating.
        @(negedge clk);
        b1.m_req = 1'b1; b1.m_we = 1'b0; b1.m_addr = 64'h180;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 64'h300;
        gcount = 0; both_gnt = 0; both_rv = 0;
        for (int c = 0; c < 60 && gcount < 10; c++) begin
            #1;
            if (b1.m_gnt && b1.d_gnt) both_gnt++;
            if (b1.m_rvalid && b1.d_rvalid) both_rv++;
            if (b1.m_gnt) begin
                gseq[gcount] = 0;
                gcount++;
            end else if (b1.d_gnt) begin
                gseq[gcount] = 1;
                gcount++;
            end
            @(negedge clk);
        end
        b1.m_req = 1'b0; b1.d_req = 1'b0;
        check("stv_gcount", 64'(gcount), 64'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stv_order%0d", i), 64'(gseq[i]), 64'(exp_seq[i]));
        end
        check("stv_both_gnt", 64'(both_gnt), 64'd0);
        check("stv_both_rvalid", 64'(both_rv), 64'd0);
        for (int c = 0; c < 10 && b1.busy; c++) begin
            @(negedge clk);
            #1;
        end
        check("stv_idle", 64'(b1.busy), 64'd0);

        // LAT=3 read with mem_err asserted.
        @(negedge clk);
        b3.m_req = 1'b1; b3.m_we = 1'b0; b3.m_addr = 64'h200;
        b3.mem_err = 1'b1; b3.mem_rdata = 64'hCAFE;
        #1;
        check("l3_gnt_T", 64'(b3.m_gnt), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            b3.m_req = 1'b0;
            #1;
            check($sformatf("l3_rEn_T%0d", k), 64'(b3.mem_rEn), 64'(k <= 4));
            check($sformatf("l3_rvalid_T%0d", k), 64'(b3.m_rvalid), 64'(k == 4));
            check($sformatf("l3_err_T%0d", k), 64'(b3.m_err), 64'(k == 4));
            check($sformatf("l3_busy_T%0d", k), 64'(b3.busy), 64'(k <= 4));
        end
        b3.mem_err = 1'b0;

        // Reset in WAIT abandons the access; pending D is granted right after.
        @(negedge clk);
        b3.m_req = 1'b1; b3.m_addr = 64'h280;
        #1;
        check("rw_gnt_T", 64'(b3.m_gnt), 64'd1);
        @(negedge clk);
        b3.m_req = 1'b0;
        @(negedge clk);
        b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 64'h3C0;
        #1;
        check("rw_no_gnt_wait", 64'(b3.d_gnt), 64'd0);
        check("rw_busy_wait", 64'(b3.busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rw_rst_busy", 64'(b3.busy), 64'd0);
        check("rw_rst_rEn", 64'(b3.mem_rEn), 64'd0);
        check("rw_rst_addr", b3.mem_addr, 64'd0);
        check("rw_rst_d_gnt", 64'(b3.d_gnt), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rw_no_rvalid%0d", k), 64'(b3.m_rvalid), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rw_d_gnt", 64'(b3.d_gnt), 64'd1);
        check("rw_m_gnt", 64'(b3.m_gnt), 64'd0);
        @(negedge clk);
        b3.d_req = 1'b0; b3.mem_rdata = 64'h1234;
        #1;
        check("rw_d_busy", 64'(b3.busy), 64'd1);
        check("rw_d_addr", b3.mem_addr, 64'h3C0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rw_d_rvalid%0d", k), 64'(b3.d_rvalid), 64'(k == 4));
            check($sformatf("rw_m_rvalid%0d", k), 64'(b3.m_rvalid), 64'd0);
        end
        check("rw_d_rdata", b3.d_rdata, 64'h1234);
        check("rw_d_err", 64'(b3.d_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
